i2c_target_core: RTL

- Synthesizable, clocked I2C target (slave) engine: samples open-drain scl/sda with the system clock, detects START/STOP/repeated START, matches a programmable address, and ACKs/NACKs.
- Write bytes go into an internal RX FIFO. Read bytes are pulled from a TX stream handshake.
- Successor to the behavioural slave model: parametrised data width, FIFO depth and synchroniser depth, plus flow control, overflow/underflow reporting and address-mismatch handling.
- Sits behind the pad open-drain buffers; used both as DUT-side target and in emulation.

---
 rtl/i2c_target_core.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_core.sv
// i2c_target_core: clocked I2C target engine. The open-drain bus is oversampled
// with the system clock. The engine detects START, STOP and repeated START,
// matches a programmable address and pushes write bytes into an RX FIFO.
// Read bytes are pulled from a TX valid/ready stream.
module i2c_target_core #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int RX_FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  input  logic [I2C_ADDR_WIDTH-1:0]         target_addr,
  output logic [I2C_DATA_WIDTH-1:0]         rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0]    rx_count,
  input  logic [I2C_DATA_WIDTH-1:0]         tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              busy,
  output logic                              rw,
  output logic                              start_det,
  output logic                              stop_det,
  output logic                              rx_overflow,
  output logic                              tx_underflow
);

  localparam int AW       = $clog2(RX_FIFO_DEPTH);
  localparam int BITS_MAX = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ? I2C_ADDR_WIDTH + 1 : I2C_DATA_WIDTH;
  localparam int CNT_W    = $clog2(BITS_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0]    scl_sync, sda_sync;
  logic                      scl_q, sda_q;
  logic                      scl_rise, scl_fall, sda_rise, sda_fall;
  logic                      start_cond, stop_cond;

  logic [CNT_W-1:0]          bit_cnt;
  logic [I2C_ADDR_WIDTH:0]   addr_sr;
  // Holds all but the bit currently on the wire. Writes complete the byte with
  // the live sda sample. Reads keep the MSB in sda_oe rather than in this register.
  logic [I2C_DATA_WIDTH-2:0] shift_sr;
  logic                      wr_drop;

  logic                      addr_done, addr_hit, data_done;
  logic                      tx_load, push, pop, fifo_full;
  logic [I2C_DATA_WIDTH-1:0] load_val, push_data;

  logic [I2C_DATA_WIDTH-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;

  assign start_cond = sda_fall & scl_q;
  assign stop_cond  = sda_rise & scl_q;
  assign addr_done  = (bit_cnt == CNT_W'(I2C_ADDR_WIDTH + 1));
  assign addr_hit   = (addr_sr[I2C_ADDR_WIDTH:1] == target_addr);
  assign data_done  = (bit_cnt == CNT_W'(I2C_DATA_WIDTH));
  assign load_val   = tx_valid ? tx_data : '1;
  assign push_data  = {shift_sr, sda_q};
  assign fifo_full  = (rx_count == (AW + 1)'(RX_FIFO_DEPTH));
  assign rx_valid   = (rx_count != '0);
  assign pop        = rx_valid & rx_ready;
  assign rx_data    = rx_valid ? mem[rd_ptr] : '0;

  // Synchronise scl/sda and register single-clock edge strobes. The sync stages
  // reset to the idle-high bus level so that no edge is reported when reset ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      sda_rise <= 1'b0;
      sda_fall <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
      scl_rise <= scl_sync[SYNC_STAGES-1] & ~scl_q;
      scl_fall <= ~scl_sync[SYNC_STAGES-1] & scl_q;
      sda_rise <= sda_sync[SYNC_STAGES-1] & ~sda_q;
      sda_fall <= ~sda_sync[SYNC_STAGES-1] & sda_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. STOP and START take priority over any in-byte transition.
  always_comb begin
    state_nxt = state;
    if (!enable)         state_nxt = IDLE;
    else if (stop_cond)  state_nxt = IDLE;
    else if (start_cond) state_nxt = ADDR;
    else begin
      case (state)
        ADDR:     if (scl_fall && addr_done) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall) state_nxt = rw ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_fall && data_done) state_nxt = wr_drop ? WAIT_STOP : WR_ACK;
        WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
        RD_DATA:  if (scl_fall && data_done) state_nxt = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_q) state_nxt = WAIT_STOP;
          else if (scl_fall)     state_nxt = RD_DATA;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output decode: bus-event pulses, FIFO push and TX stream handshake.
  always_comb begin
    start_det    = enable & start_cond;
    stop_det     = enable & stop_cond;
    tx_load      = 1'b0;
    push         = 1'b0;
    rx_overflow  = 1'b0;
    tx_ready     = 1'b0;
    tx_underflow = 1'b0;
    if (enable && !start_cond && !stop_cond) begin
      case (state)
        ADDR_ACK: tx_load = scl_fall & rw;
        RD_ACK:   tx_load = scl_fall;
        WR_DATA: begin
          if (scl_rise && bit_cnt == CNT_W'(I2C_DATA_WIDTH - 1)) begin
            push        = ~fifo_full;
            rx_overflow = fifo_full;
          end
        end
        default: tx_load = 1'b0;
      endcase
    end
    if (tx_load) begin
      tx_ready     = tx_valid;
      tx_underflow = ~tx_valid;
    end
  end

  // Datapath: bit counter, shift registers, sda drive, busy and rw flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      addr_sr  <= '0;
      shift_sr <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      wr_drop  <= 1'b0;
    end else if (!enable || stop_cond) begin
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else if (start_cond) begin
      bit_cnt <= '0;
      wr_drop <= 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && !addr_done) begin
            addr_sr <= {addr_sr[I2C_ADDR_WIDTH-1:0], sda_q};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else if (scl_fall && addr_done) begin
            if (addr_hit) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= addr_sr[0];
            end else begin
              busy   <= 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            wr_drop <= 1'b0;
            if (rw) begin
              shift_sr <= load_val[I2C_DATA_WIDTH-2:0];
              sda_oe   <= ~load_val[I2C_DATA_WIDTH-1];
              bit_cnt  <= CNT_W'(1);
            end else begin
              sda_oe   <= 1'b0;
              bit_cnt  <= '0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && !data_done) begin
            shift_sr <= (shift_sr << 1) | (I2C_DATA_WIDTH - 1)'(sda_q);
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (rx_overflow) wr_drop <= 1'b1;
          end else if (scl_fall && data_done && !wr_drop) begin
            sda_oe <= 1'b1;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (data_done) begin
              sda_oe <= 1'b0;
            end else begin
              sda_oe   <= ~shift_sr[I2C_DATA_WIDTH-2];
              shift_sr <= shift_sr << 1;
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            shift_sr <= load_val[I2C_DATA_WIDTH-2:0];
            sda_oe   <= ~load_val[I2C_DATA_WIDTH-1];
            bit_cnt  <= CNT_W'(1);
          end
        end
        default: sda_oe <= 1'b0;
      endcase
    end
  end

  // RX FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      rx_count <= rx_count + (AW + 1)'(1);
      else if (!push && pop) rx_count <= rx_count - (AW + 1)'(1);
    end
  end

  // RX FIFO storage; contents need no reset because rx_data is gated by rx_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule
